// File: rtl/multitug3_rei_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multitug3_rei_tx: TUG-3 TX mux, V5 REI insertion, output FIFO, BIP-8.       |
// | Optional: MTUG3_TX_BIP8_EN enables the per-frame BIP-8 accumulator.         |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module multitug3_rei_tx #(
  parameter int               WIDTH   = 8,
  parameter int               NCH     = 21,
  parameter int               CIDW    = 5,
  parameter int               DEPTH   = 16,
  parameter int               AW      = 4,
  parameter int               REI_BIT = 5,
  parameter logic [WIDTH-1:0] FILL    = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              txsof,
  input  logic [NCH-1:0]    rei_vld,
  input  logic [NCH-1:0]    rei,
  input  logic              di_vld,
  input  logic [WIDTH-1:0]  datain,
  input  logic [CIDW-1:0]   oid,
  input  logic              di_v5,
  input  logic              entug3,
  output logic [WIDTH-1:0]  dotug3,
  output logic              do_vld,
  output logic [WIDTH-1:0]  tug3bip8,
  output logic              bip_vld,
  output logic              ovf,
  output logic              udf,
  output logic [AW:0]       fifo_lvl
);

  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

  logic [NCH-1:0]   r_pend;
  logic             r_s1_vld;
  logic [WIDTH-1:0] r_s1_data;
  logic [NCH-1:0]   w_v5_onehot;
  logic             w_v5_hit;
  logic             w_rei_sel;
  logic [WIDTH-1:0] w_s1_data;

  // One-hot of the tributary whose V5 is consumed this cycle; out-of-range ids never match.
  always_comb begin
    w_v5_onehot = '0;
    for (int i = 0; i < NCH; i++) begin
      if (oid == CIDW'(i)) w_v5_onehot[i] = di_vld & di_v5;
    end
  end

  assign w_v5_hit  = |w_v5_onehot;
  assign w_rei_sel = |(w_v5_onehot & ((rei_vld & rei) | (~rei_vld & r_pend)));

  always_comb begin
    w_s1_data = datain;
    if (w_v5_hit) w_s1_data[REI_BIT] = w_rei_sel;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_data <= '0;
      r_pend    <= '0;
    end else begin
      r_s1_vld <= di_vld;
      if (di_vld) r_s1_data <= w_s1_data;
      r_pend <= ((r_pend & ~rei_vld) | (rei & rei_vld)) & ~w_v5_onehot;
    end
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_cnt;
  logic             w_rd;
  logic             w_wr;

  // A read in the same cycle frees a slot, so a full FIFO still accepts the write.
  assign w_rd     = entug3 & (r_cnt != '0);
  assign w_wr     = r_s1_vld & ((r_cnt != C_DEPTH) | w_rd);
  assign fifo_lvl = r_cnt;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= r_s1_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      dotug3 <= '0;
      do_vld <= 1'b0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_rd);
      if (r_s1_vld && !w_wr) ovf <= 1'b1;
      if (entug3) begin
        if (w_rd) begin
          dotug3 <= r_mem[r_rptr];
          do_vld <= 1'b1;
        end else begin
          dotug3 <= FILL;
          do_vld <= 1'b0;
          udf    <= 1'b1;
        end
      end else begin
        do_vld <= 1'b0;
      end
    end
  end

`ifdef MTUG3_TX_BIP8_EN
  logic [WIDTH-1:0] r_acc;

  // The byte on dotug3 during txsof still belongs to the frame being closed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc    <= '0;
      tug3bip8 <= '0;
      bip_vld  <= 1'b0;
    end else if (txsof) begin
      tug3bip8 <= r_acc ^ (do_vld ? dotug3 : '0);
      r_acc    <= '0;
      bip_vld  <= 1'b1;
    end else begin
      bip_vld <= 1'b0;
      if (do_vld) r_acc <= r_acc ^ dotug3;
    end
  end
`else
  logic w_unused_txsof;
  assign w_unused_txsof = txsof;
  assign tug3bip8       = '0;
  assign bip_vld        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multitug3_rei_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_multitug3_rei_tx: randomized + directed bench with a queue-based model.  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_multitug3_rei_tx;
  localparam int WIDTH = 8, NCH = 21, CIDW = 5, DEPTH = 16, AW = 4, REI_BIT = 5;
  localparam logic [7:0] FILL = 8'h00;
`ifdef MTUG3_TX_BIP8_EN
  localparam bit BIP_EN = 1'b1;
`else
  localparam bit BIP_EN = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1, txsof = 1'b0, di_vld = 1'b0, di_v5 = 1'b0, entug3 = 1'b0;
  logic [NCH-1:0] rei_vld = '0, rei = '0;
  logic [7:0] datain = '0;
  logic [CIDW-1:0] oid = '0;
  logic [7:0] dotug3, tug3bip8;
  logic do_vld, bip_vld, ovf, udf;
  logic [AW:0] fifo_lvl;

  int vectors = 0, miscompares = 0;

  multitug3_rei_tx #(.WIDTH(WIDTH), .NCH(NCH), .CIDW(CIDW), .DEPTH(DEPTH), .AW(AW),
                     .REI_BIT(REI_BIT), .FILL(FILL)) dut (
    .clk(clk), .rst(rst), .txsof(txsof), .rei_vld(rei_vld), .rei(rei),
    .di_vld(di_vld), .datain(datain), .oid(oid), .di_v5(di_v5), .entug3(entug3),
    .dotug3(dotug3), .do_vld(do_vld), .tug3bip8(tug3bip8), .bip_vld(bip_vld),
    .ovf(ovf), .udf(udf), .fifo_lvl(fifo_lvl));

  always #5 clk = ~clk;

  // Behavioural model
  logic [NCH-1:0] m_pend;
  logic m_s1v, m_dvld, m_bvld, m_ovf, m_udf;
  logic [7:0] m_s1d, m_dout, m_bip, m_acc;
  logic [7:0] m_q[$];

  task automatic model_reset();
    m_pend = '0; m_s1v = 0; m_s1d = 0; m_dout = 0; m_dvld = 0;
    m_bip = 0; m_bvld = 0; m_acc = 0; m_ovf = 0; m_udf = 0;
    m_q.delete();
  endtask

  task automatic model_edge();
    logic [7:0] nd;
    logic nv;
    logic [7:0] d;
    nd = m_dout; nv = 0;
    if (BIP_EN) begin
      if (txsof) begin
        m_bip = m_acc ^ (m_dvld ? m_dout : 8'h00); m_acc = 0; m_bvld = 1;
      end else begin
        m_bvld = 0;
        if (m_dvld) m_acc = m_acc ^ m_dout;
      end
    end
    if (entug3) begin
      if (m_q.size() > 0) begin nd = m_q.pop_front(); nv = 1; end
      else begin nd = FILL; m_udf = 1; end
    end
    if (m_s1v) begin
      if (m_q.size() < DEPTH) m_q.push_back(m_s1d); else m_ovf = 1;
    end
    m_dout = nd; m_dvld = nv;
    m_s1v = di_vld;
    if (di_vld) begin
      d = datain;
      if (di_v5 && oid < NCH) d[REI_BIT] = rei_vld[oid] ? rei[oid] : m_pend[oid];
      m_s1d = d;
    end
    for (int i = 0; i < NCH; i++) if (rei_vld[i]) m_pend[i] = rei[i];
    if (di_vld && di_v5 && oid < NCH) m_pend[oid] = 1'b0;
  endtask

  task automatic idle_inputs();
    txsof = 0; di_vld = 0; di_v5 = 0; entug3 = 0; rei_vld = '0; rei = '0; datain = '0; oid = '0;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
  endtask

  task automatic put(input logic [7:0] b, input logic v5, input logic [CIDW-1:0] id);
    di_vld = 1; datain = b; di_v5 = v5; oid = id;
    step();
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({dotug3, do_vld, tug3bip8, bip_vld, ovf, udf, fifo_lvl} !== '0) begin
      miscompares++;
      $display("FAIL reset outputs dotug3=%h do_vld=%b bip=%h bip_vld=%b ovf=%b udf=%b lvl=%0d, required all 0",
               dotug3, do_vld, tug3bip8, bip_vld, ovf, udf, fifo_lvl);
    end
    rst = 1;
  endtask

  task automatic test_rei_insert();
    do_reset();
    rei_vld[3] = 1; rei[3] = 1; step(); idle_inputs();
    put(8'h00, 1, 5'd3);
    vectors++;
    if (fifo_lvl !== 5'd0) begin miscompares++; $display("FAIL wr_latency0 lvl=%0d exp=0", fifo_lvl); end
    put(8'h00, 1, 5'd3);
    vectors++;
    if (fifo_lvl !== 5'd1) begin miscompares++; $display("FAIL wr_latency1 lvl=%0d exp=1", fifo_lvl); end
    step();
    entug3 = 1; step();
    vectors++;
    if (dotug3 !== 8'h20 || do_vld !== 1'b1) begin
      miscompares++; $display("FAIL rei_set dotug3=%h vld=%b exp=20/1", dotug3, do_vld);
    end
    step();
    vectors++;
    if (dotug3 !== 8'h00 || do_vld !== 1'b1) begin
      miscompares++; $display("FAIL rei_consumed dotug3=%h vld=%b exp=00/1", dotug3, do_vld);
    end
    idle_inputs(); step();
    vectors++;
    if (do_vld !== 1'b0 || dotug3 !== 8'h00) begin
      miscompares++; $display("FAIL no_read_hold dotug3=%h vld=%b exp=00/0", dotug3, do_vld);
    end
  endtask

  task automatic test_bypass();
    logic [7:0] exp_b[4];
    exp_b = '{8'hDF, 8'h00, 8'h20, 8'h00};
    do_reset();
    rei_vld[7] = 1; rei[7] = 1; step(); idle_inputs();
    rei_vld[7] = 1; rei[7] = 0; di_vld = 1; di_v5 = 1; oid = 7; datain = 8'hFF; step(); idle_inputs();
    put(8'h00, 1, 5'd7);
    rei_vld[7] = 1; rei[7] = 1; di_vld = 1; di_v5 = 1; oid = 7; datain = 8'h00; step(); idle_inputs();
    put(8'h00, 1, 5'd7);
    step();
    entug3 = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++;
      if (dotug3 !== exp_b[i] || do_vld !== 1'b1) begin
        miscompares++; $display("FAIL bypass[%0d] dotug3=%h vld=%b exp=%h/1", i, dotug3, do_vld, exp_b[i]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 20; i++) put(8'h10 + 8'(i), 0, 5'd0);
    step(); step();
    vectors++;
    if (fifo_lvl !== 5'd16 || ovf !== 1'b1 || udf !== 1'b0) begin
      miscompares++; $display("FAIL ovf_full lvl=%0d ovf=%b udf=%b exp=16/1/0", fifo_lvl, ovf, udf);
    end
    entug3 = 1;
    for (int i = 0; i < 16; i++) begin
      step();
      vectors++;
      if (dotug3 !== 8'h10 + 8'(i) || do_vld !== 1'b1) begin
        miscompares++; $display("FAIL drain[%0d] dotug3=%h vld=%b exp=%h/1", i, dotug3, do_vld, 8'h10 + 8'(i));
      end
    end
    step();
    vectors++;
    if (dotug3 !== FILL || do_vld !== 1'b0 || udf !== 1'b1 || fifo_lvl !== 5'd0) begin
      miscompares++; $display("FAIL underflow dotug3=%h vld=%b udf=%b lvl=%0d exp=%h/0/1/0", dotug3, do_vld, udf, fifo_lvl, FILL);
    end
    idle_inputs();
  endtask

  task automatic test_full_rw();
    do_reset();
    for (int i = 0; i < 16; i++) put(8'h40 + 8'(i), 0, 5'd0);
    step();
    vectors++;
    if (fifo_lvl !== 5'd16 || ovf !== 1'b0) begin
      miscompares++; $display("FAIL full_exact lvl=%0d ovf=%b exp=16/0", fifo_lvl, ovf);
    end
    put(8'hAA, 0, 5'd0);
    entug3 = 1; step();
    vectors++;
    if (fifo_lvl !== 5'd16 || ovf !== 1'b0 || dotug3 !== 8'h40) begin
      miscompares++; $display("FAIL full_rw lvl=%0d ovf=%b dotug3=%h exp=16/0/40", fifo_lvl, ovf, dotug3);
    end
    repeat (16) step();
    vectors++;
    if (dotug3 !== 8'hAA || do_vld !== 1'b1) begin
      miscompares++; $display("FAIL full_rw_last dotug3=%h vld=%b exp=aa/1", dotug3, do_vld);
    end
    idle_inputs();
  endtask

  task automatic test_bip();
    logic [7:0] e7;
    e7 = BIP_EN ? 8'h07 : 8'h00;
    do_reset();
    put(8'h01, 0, 5'd0); put(8'h02, 0, 5'd0); put(8'h04, 0, 5'd0);
    step();
    entug3 = 1; step(); step(); step();
    idle_inputs();
    txsof = 1; step(); txsof = 0;
    vectors++;
    if (bip_vld !== BIP_EN || tug3bip8 !== e7) begin
      miscompares++; $display("FAIL bip_frame bip_vld=%b bip=%h exp=%b/%h", bip_vld, tug3bip8, BIP_EN, e7);
    end
    step();
    vectors++;
    if (bip_vld !== 1'b0 || tug3bip8 !== e7) begin
      miscompares++; $display("FAIL bip_hold bip_vld=%b bip=%h exp=0/%h", bip_vld, tug3bip8, e7);
    end
    txsof = 1; step(); txsof = 0;
    vectors++;
    if (bip_vld !== BIP_EN || tug3bip8 !== 8'h00) begin
      miscompares++; $display("FAIL bip_empty bip_vld=%b bip=%h exp=%b/00", bip_vld, tug3bip8, BIP_EN);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int i = 0; i < 6; i++) put(8'h31 + 8'(i), 0, 5'd0);
    step();
    entug3 = 1; step(); entug3 = 0;
    vectors++;
    if (fifo_lvl !== 5'd5 || dotug3 !== 8'h31) begin
      miscompares++; $display("FAIL pre_rst lvl=%0d dotug3=%h exp=5/31", fifo_lvl, dotug3);
    end
    #2 rst = 0;
    #1;
    vectors++;
    if ({dotug3, do_vld, tug3bip8, bip_vld, ovf, udf, fifo_lvl} !== '0) begin
      miscompares++; $display("FAIL async_rst dotug3=%h vld=%b lvl=%0d, required all 0", dotug3, do_vld, fifo_lvl);
    end
    model_reset();
    @(posedge clk); #1;
    rst = 1;
    entug3 = 1; step(); entug3 = 0;
    vectors++;
    if (udf !== 1'b1 || dotug3 !== FILL || do_vld !== 1'b0) begin
      miscompares++; $display("FAIL post_rst_udf udf=%b dotug3=%h vld=%b exp=1/%h/0", udf, dotug3, do_vld, FILL);
    end
  endtask

  task automatic test_oid_range();
    logic [7:0] exp_b[3];
    exp_b = '{8'h00, 8'h20, 8'h20};
    do_reset();
    rei_vld = '1; rei = '1; step(); idle_inputs();
    put(8'h00, 1, 5'd25); put(8'h00, 1, 5'd4); put(8'h00, 1, 5'd9);
    step();
    entug3 = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (dotug3 !== exp_b[i]) begin
        miscompares++; $display("FAIL oid_range[%0d] dotug3=%h exp=%h", i, dotug3, exp_b[i]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      di_vld  = ($urandom_range(0, 99) < 60);
      di_v5   = ($urandom_range(0, 3) == 0);
      oid     = CIDW'($urandom_range(0, 31));
      datain  = 8'($urandom);
      rei_vld = NCH'($urandom & $urandom & $urandom);
      rei     = NCH'($urandom);
      entug3  = ($urandom_range(0, 99) < ((n / 500) % 2 == 0 ? 45 : 75));
      txsof   = ($urandom_range(0, 39) == 0);
      step();
      vectors++;
      if (dotug3 !== m_dout || do_vld !== m_dvld || tug3bip8 !== m_bip || bip_vld !== m_bvld ||
          ovf !== m_ovf || udf !== m_udf || fifo_lvl !== (AW+1)'(m_q.size())) begin
        miscompares++;
        $display("FAIL random[%0d] got do=%h/%b bip=%h/%b ovf=%b udf=%b lvl=%0d exp do=%h/%b bip=%h/%b ovf=%b udf=%b lvl=%0d",
                 n, dotug3, do_vld, tug3bip8, bip_vld, ovf, udf, fifo_lvl,
                 m_dout, m_dvld, m_bip, m_bvld, m_ovf, m_udf, m_q.size());
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_rei_insert();
    test_bypass();
    test_overflow();
    test_full_rw();
    test_bip();
    test_reset_midstream();
    test_oid_range();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/multitug3_rei_tx.md
# multitug3_rei_tx

Parametrised TUG-3 transmit multiplexer/back-reporter that replaces the fixed 21-channel TU-12 multiframe TX plus TUG-3 TX pair. It accepts the framer's byte stream tagged with a tributary id, inserts per-tributary REI bits from the receive side into each V5 byte, and buffers the result in a FIFO drained by the TX memory. It also computes a per-frame BIP-8 over the drained bytes for the VC-4 TX. It sits between the framer and the VC-4 TX memory in the clk19 domain.

## Interface
- WIDTH, 8, byte width
- NCH, 21, tributary count (1..32)
- CIDW, 5, oid width; 2^CIDW >= NCH
- DEPTH, 16, FIFO depth, power of 2, >= 4
- AW, 4, log2(DEPTH)
- REI_BIT, 5, bit index of REI inside V5 (V5 b3, MSB = b1)
- FILL, 8'h00, byte driven on underflow

Ports:
- clk  in  1  clk19
- rst  in  1  reset, asynchronous, active-low
- txsof  in  1  frame start pulse from memory
- rei_vld  in  NCH  per-tributary REI event strobe
- rei  in  NCH  per-tributary REI value, qualified by rei_vld[i]
- di_vld  in  1  input byte valid
- datain  in  WIDTH  input byte
- oid  in  CIDW  tributary id of datain
- di_v5  in  1  datain is the V5 byte of tributary oid
- entug3  in  1  read request from memory
- dotug3  out  WIDTH  output byte
- do_vld  out  1  dotug3 carries a FIFO byte
- tug3bip8  out  WIDTH  BIP-8 of the last closed frame
- bip_vld  out  1  one-cycle strobe, tug3bip8 updated
- ovf  out  1  sticky: byte dropped on full FIFO
- udf  out  1  sticky: read on empty FIFO
- fifo_lvl  out  AW+1  FIFO occupancy

## Operation
- REI store: NCH pending bits `pend[i]`. rei_vld[i] sets pend[i] <= rei[i]. The last event wins.
- Insertion stage (S1): on di_vld & di_v5 & oid < NCH, bit REI_BIT of the byte is replaced by pend[oid]. If rei_vld[oid] is high in the same cycle, rei[oid] is used instead (bypass).
- After the V5 byte is consumed, pend[oid] clears to 0. A same-cycle bypass event is also consumed, so pend[oid] ends at 0.
- Non-V5 bytes and bytes with oid >= NCH pass through unmodified. oid >= NCH has no effect on pend.
- FIFO: S1 output is written when valid.
  - Full with a write pending: the byte is dropped and ovf sets.
  - Simultaneous read and write with the FIFO full: the read frees the slot, so the write is accepted.
- Read: entug3 with the FIFO non-empty pops a byte: dotug3 <= head, do_vld <= 1.
- Read on empty: dotug3 <= FILL, do_vld <= 0, udf sets.
- No entug3: do_vld <= 0 and dotug3 holds its value.
- Pointers wrap modulo DEPTH. Occupancy is tracked with an AW+1-bit counter.
- BIP-8: the accumulator XORs dotug3 in every cycle do_vld is high, including FILL-free bytes only.
  - txsof closes the frame. The byte visible in the txsof cycle belongs to the closing frame: tug3bip8 <= acc ^ (do_vld ? dotug3 : 0), acc <= 0, bip_vld <= 1 for one cycle.
- ovf and udf clear only on reset.

## Timing
- Reset (rst low, async): dotug3 = 0, do_vld = 0, tug3bip8 = 0, bip_vld = 0, ovf = 0, udf = 0, fifo_lvl = 0, pend = 0, pointers = 0, acc = 0.
  - Reset mid-frame discards FIFO contents and the partial BIP.
- Write path: di_vld in cycle t -> S1 registered at edge t -> FIFO write at edge t+1 -> fifo_lvl increments, visible in cycle t+2.
- Read path: entug3 in cycle k -> dotug3/do_vld valid in cycle k+1.
- Minimum datain -> dotug3 latency: 3 cycles (entug3 asserted in cycle t+2).
- bip_vld is high in the cycle after txsof. tug3bip8 is stable until the next txsof.
- Back-to-back txsof gives tug3bip8 = the XOR of the single intervening frame (0 if it was empty).

## Configuration
- MTUG3_TX_BIP8_EN defined: BIP-8 accumulator, tug3bip8 and bip_vld are implemented as described.
- Undefined: no accumulator is built; tug3bip8 is tied to 0 and bip_vld to 0. txsof is ignored. All other behaviour is unchanged.

## Test plan
- rei_vld[3]=1, rei[3]=1, then V5 byte 8'h00 with oid=3 -> output byte 8'h20; the next V5 for oid 3 outputs 8'h00.
- V5 byte 8'hFF with oid=7, rei_vld[7]=1 and rei[7]=0 in the same cycle -> output 8'hDF; pend[7]=0 afterwards.
- 20 writes with no reads (DEPTH=16) -> fifo_lvl=16, ovf=1. Draining yields the first 16 bytes in order; the 17th entug3 gives dotug3=FILL, do_vld=0, udf=1.
- Frame of bytes 8'h01, 8'h02, 8'h04 drained, txsof in the cycle 8'h04 is visible -> bip_vld in the next cycle with tug3bip8=8'h07. The following empty frame gives 8'h00.
- rst pulsed low mid-stream with fifo_lvl=5 -> all outputs 0 immediately. After release, entug3 gives udf=1 and FILL.
- oid=25 with NCH=21 and di_v5=1, byte 8'h00, pend preloaded -> byte passes as 8'h00 and pend is unchanged.
